// File: rtl/fitness_sequencer.sv
// Fitness sequencer: drives all eight input vectors into a candidate 1-bit full
// adder, compares the responses with an internal reference and scores the result.
module fitness_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_ci,
  input  logic       dut_sum,
  input  logic       dut_co,
  output logic       busy,
  output logic       done,
  output logic [4:0] fitness,
  output logic [7:0] pass_mask
);

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [2:0] vec, vec_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [4:0] fitness_nxt;
  logic [7:0] mask_nxt;
  logic [2:0] drive_q, drive_nxt;
  logic       busy_nxt, done_nxt;
  logic       sum_exp, co_exp, sum_ok, co_ok;

  // Reference full adder for the vector currently driven.
  always_comb begin
    sum_exp = ^vec;
    co_exp  = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
    // Case equality so an X/Z response scores as a mismatch in simulation.
    sum_ok  = (dut_sum === sum_exp);
    co_ok   = (dut_co === co_exp);
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_nxt   = state;
    vec_nxt     = vec;
    cnt_nxt     = cnt;
    fitness_nxt = fitness;
    mask_nxt    = pass_mask;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = APPLY;
          vec_nxt     = 3'd0;
          cnt_nxt     = 4'd0;
          fitness_nxt = 5'd0;
          mask_nxt    = 8'd0;
        end
      end
      APPLY: begin
        cnt_nxt = cnt + 4'd1;
        if (cnt == SETTLE_LAST) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        fitness_nxt   = fitness + 5'(sum_ok) + 5'(co_ok);
        mask_nxt[vec] = sum_ok & co_ok;
        if (vec == 3'd7) begin
          state_nxt = DONE;
        end else begin
          state_nxt = APPLY;
          vec_nxt   = vec + 3'd1;
          cnt_nxt   = 4'd0;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change cleanly on the edge.
  always_comb begin
    busy_nxt  = (state_nxt == APPLY) || (state_nxt == SAMPLE);
    done_nxt  = (state_nxt == DONE);
    drive_nxt = busy_nxt ? vec_nxt : 3'd0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      vec       <= 3'd0;
      cnt       <= 4'd0;
      fitness   <= 5'd0;
      pass_mask <= 8'd0;
      drive_q   <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      vec       <= vec_nxt;
      cnt       <= cnt_nxt;
      fitness   <= fitness_nxt;
      pass_mask <= mask_nxt;
      drive_q   <= drive_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  assign {dut_a, dut_b, dut_ci} = drive_q;

endmodule

// File: tb/tb_fitness_sequencer.sv
// Directed bench for fitness_sequencer: table of candidate adders scored at
// SETTLE_CYCLES=1, plus settle=3, ignored-start and mid-run reset sequences.
module tb_fitness_sequencer;

  logic clk;
  logic rst;

  logic       start1, a1, b1, c1, s1, co1, busy1, done1;
  logic [4:0] fit1;
  logic [7:0] mask1;
  int         mode1;

  logic       start3, a3, b3, c3, s3, co3, busy3, done3;
  logic [4:0] fit3;
  logic [7:0] mask3;
  int         mode3;

  int n_cmp;
  int n_fail;

  fitness_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .dut_a(a1), .dut_b(b1), .dut_ci(c1), .dut_sum(s1), .dut_co(co1),
    .busy(busy1), .done(done1), .fitness(fit1), .pass_mask(mask1)
  );

  fitness_sequencer #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .dut_a(a3), .dut_b(b3), .dut_ci(c3), .dut_sum(s3), .dut_co(co3),
    .busy(busy3), .done(done3), .fitness(fit3), .pass_mask(mask3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Candidate circuits: 0 correct adder, 1 sum=0/co=b&~a, 2 const 0, 3 const 1,
  // 4 correct sum with inverted carry.
  function automatic logic [1:0] cand(input int mode, input logic a, input logic b, input logic ci);
    logic maj;
    maj = (a & b) | (a & ci) | (b & ci);
    case (mode)
      0:       return {a ^ b ^ ci, maj};
      1:       return {1'b0, b & ~a};
      2:       return 2'b00;
      3:       return 2'b11;
      4:       return {a ^ b ^ ci, ~maj};
      default: return 2'b00;
    endcase
  endfunction

  always_comb {s1, co1} = cand(mode1, a1, b1, c1);
  always_comb {s3, co3} = cand(mode3, a3, b3, c3);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_start(input int which, input logic val);
    if (which == 1) start1 = val;
    else            start3 = val;
  endtask

  task automatic get_obs(input int which, output logic [2:0] v, output logic b,
                         output logic d, output logic [4:0] f, output logic [7:0] m);
    if (which == 1) begin
      v = {a1, b1, c1}; b = busy1; d = done1; f = fit1; m = mask1;
    end else begin
      v = {a3, b3, c3}; b = busy3; d = done3; f = fit3; m = mask3;
    end
  endtask

  // One full evaluation. Cycle k is the cycle ending at edge T+k (T = accepting
  // edge); outputs are sampled on the falling edge inside it. Done must land in
  // cycle T+1+8*(settle+1).
  task automatic run_eval(input int which, input int settle, input int mode,
                          input int exp_fit, input logic [7:0] exp_mask,
                          input int repulse_at, input bit release_rst, input bit poke_done);
    int         span;
    int         done_at;
    logic [2:0] v;
    logic       b, d;
    logic [4:0] f;
    logic [7:0] m;
    span    = 8 * (settle + 1);
    done_at = 0;
    if (which == 1) mode1 = mode;
    else            mode3 = mode;
    @(negedge clk);
    if (release_rst) rst = 1'b1;
    drive_start(which, 1'b1);
    @(posedge clk);
    for (int k = 1; k <= span + 4; k++) begin
      @(negedge clk);
      drive_start(which, (k == repulse_at) ? 1'b1 : 1'b0);
      get_obs(which, v, b, d, f, m);
      if (k == 1) check("clear_on_start", {19'd0, f, m}, 32'd0);
      if (k <= span) begin
        check($sformatf("hold_k%0d", k), {27'd0, d, b, v},
              {27'd0, 1'b0, 1'b1, 3'((k - 1) / (settle + 1))});
      end else if (d) begin
        done_at = k;
        break;
      end
    end
    check("done_cycle", done_at, span + 1);
    if (done_at != 0) begin
      check("done_outs", {28'd0, b, v}, 32'd0);
      check("fitness", {27'd0, f}, exp_fit);
      check("pass_mask", {24'd0, m}, {24'd0, exp_mask});
      if (poke_done) drive_start(which, 1'b1);
      @(negedge clk);
      drive_start(which, 1'b0);
      get_obs(which, v, b, d, f, m);
      check("after_done", {27'd0, d, b, v}, 32'd0);
      check("result_hold", {19'd0, f, m}, {19'd0, 5'(exp_fit), exp_mask});
      if (poke_done) begin
        @(negedge clk);
        get_obs(which, v, b, d, f, m);
        check("start_in_done_ignored", {27'd0, d, b, v}, 32'd0);
      end
    end
  endtask

  typedef struct {
    int         mode;
    int         fit;
    logic [7:0] mask;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic       found;
    logic       seen;
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    mode1  = 0;
    mode3  = 0;

    tbl[0] = '{mode: 0, fit: 16, mask: 8'hFF};
    tbl[1] = '{mode: 1, fit: 8,  mask: 8'h09};
    tbl[2] = '{mode: 2, fit: 8,  mask: 8'h01};
    tbl[3] = '{mode: 3, fit: 8,  mask: 8'h80};
    tbl[4] = '{mode: 4, fit: 8,  mask: 8'h00};

    repeat (3) @(negedge clk);
    check("reset_dut1", {15'd0, busy1, done1, a1, b1, c1, fit1, mask1}, 32'd0);
    check("reset_dut3", {15'd0, busy3, done3, a3, b3, c3, fit3, mask3}, 32'd0);

    // First run releases reset and starts on the very next edge.
    for (int i = 0; i < 5; i++)
      run_eval(1, 1, tbl[i].mode, tbl[i].fit, tbl[i].mask, 0, i == 0, i == 4);

    // Longer settle, with a start re-pulse at T+10 that must be ignored.
    run_eval(3, 3, 0, 16, 8'hFF, 10, 1'b0, 1'b0);

    // Reset in the middle of vector 4 aborts the run without a done pulse.
    mode1 = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    found  = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if ({a1, b1, c1} == 3'd4 && busy1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reach_vec4", {31'd0, found}, 32'd1);
    check("partial_fitness", {27'd0, fit1}, 32'd8);
    rst = 1'b0;
    #1;
    check("rst_async", {15'd0, busy1, done1, a1, b1, c1, fit1, mask1}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seen = seen | done1 | busy1;
    end
    check("no_done_in_rst", {31'd0, seen}, 32'd0);
    run_eval(1, 1, 0, 16, 8'hFF, 0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fitness_sequencer.md
FITNESS_SEQUENCER -- requirements
Module: fitness_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, is the number of cycles the controller holds each test vector before sampling the candidate outputs; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low (0 = reset).
REQ-004 start  input  1  single-cycle request to run one full evaluation; accepted only in IDLE.
REQ-005 dut_a  output  1  operand a driven into the candidate 1-bit full adder.
REQ-006 dut_b  output  1  operand b driven into the candidate.
REQ-007 dut_ci  output  1  carry-in driven into the candidate.
REQ-008 dut_sum  input  1  sum returned by the candidate (combinational from dut_a/b/ci).
REQ-009 dut_co  input  1  carry-out returned by the candidate.
REQ-010 busy  output  1  high from the cycle after start is accepted through the last SAMPLE cycle.
REQ-011 done  output  1  single-cycle pulse marking evaluation complete.
REQ-012 fitness  output  5  match count, range 0..16 (one point per correct sum, one per correct co).
REQ-013 pass_mask  output  8  bit v set when vector v matched on both sum and co.

Function
REQ-014 FSM states: IDLE, APPLY, SAMPLE, DONE; registered state, no other encodings reachable.
REQ-015 IDLE: busy=0, done=0, dut_a/b/ci=0; start=1 -> APPLY with vector index v=0, settle counter=0, fitness=0, pass_mask=0.
REQ-016 Vector v (3-bit, 0..7) drives {dut_a,dut_b,dut_ci}=v[2:0]; outputs registered, stable for the whole APPLY+SAMPLE window of that vector.
REQ-017 Expected values computed internally: sum_exp = a^b^ci; co_exp = (a&b)|(a&ci)|(b&ci); no external vector memory.
REQ-018 APPLY: counter increments each cycle; when counter reaches SETTLE_CYCLES-1, next state SAMPLE.
REQ-019 SAMPLE (one cycle): on its closing edge fitness += (dut_sum==sum_exp) + (dut_co==co_exp); pass_mask[v] <= both equal.
REQ-020 SAMPLE with v<7 -> APPLY, v<=v+1, counter<=0; SAMPLE with v==7 -> DONE, no wrap to 0 within a run.
REQ-021 DONE (one cycle): done=1, busy=0, dut_a/b/ci=0; unconditional return to IDLE.
REQ-022 Latency: start accepted at edge T -> done high in cycle T+1+8*(SETTLE_CYCLES+1); SETTLE_CYCLES=1 gives T+17.
REQ-023 start while busy or in DONE is ignored; no queuing, no restart, results unaffected.
REQ-024 fitness and pass_mask hold their final values from DONE until the next accepted start, which clears both on the same edge.
REQ-025 dut_sum/dut_co of X or Z count as mismatch; fitness never exceeds 16 and never wraps.

Reset
REQ-026 rst=0 forces, asynchronously, state=IDLE, v=0, counter=0, busy=0, done=0, dut_a/b/ci=0, fitness=0, pass_mask=0.
REQ-027 Reset asserted mid-run aborts the run with no done pulse; after release the block waits in IDLE for a fresh start.
REQ-028 start sampled high on the first edge after rst release is accepted normally.

Verification
REQ-029 Correct full adder as candidate, SETTLE_CYCLES=1, start pulse at T -> done at T+17, fitness=16, pass_mask=8'hFF.
REQ-030 Candidate sum=0, co=b&~a -> fitness=8, pass_mask=8'h09.
REQ-031 Candidate outputs tied to constant 0 -> fitness=8, pass_mask=8'h01; constant 1 -> fitness=8, pass_mask=8'h80.
REQ-032 SETTLE_CYCLES=3, correct adder, start at T -> done at T+33; start re-pulsed at T+10 ignored, fitness=16.
REQ-033 rst pulled low during vector 4 -> all outputs 0 immediately, no done; new start after release -> full run, fitness=16.
REQ-034 Each applied vector held exactly SETTLE_CYCLES+1 cycles, sequence 0..7 in order, checked against a reference model.
